// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding for the instruction-memory boot loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_CHECK, ST_DONE, ST_ERROR
  } state_e;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: packs little-endian bytes into 32-bit words and strobes each completed word one cycle later.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  data_i,
  output logic [1:0]  lane_o,
  output logic        word_vld_o,
  output logic [31:0] word_o
);
  logic [1:0]  lane_q;
  logic [31:0] word_q;
  logic        vld_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= byte_en_i && !clear_i && lane_q == 2'd3;
      if (clear_i) lane_q <= '0;
      else if (byte_en_i) begin
        lane_q <= lane_q + 2'd1;
        word_q[{lane_q, 3'b000} +: 8] <= data_i;
      end
    end
  end
  assign lane_o     = lane_q;
  assign word_vld_o = vld_q;
  assign word_o     = word_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a framed, checksummed byte stream into instruction memory and releases the core on success.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wd,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;
  state_e      state_q, state_d;
  logic [15:0] n_q, n_d, idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [1:0]  lane;
  logic        xfer, clear;
  assign s_ready = state_q inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CHECK};
  assign xfer    = s_valid && s_ready;
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q + 16'(imem_we);
    chk_d   = chk_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) begin
        state_d = ST_LEN0;
        idx_d   = '0;
        chk_d   = '0;
        clear   = 1'b1;
      end
      ST_LEN0: if (xfer) begin
        n_d[7:0] = s_data;
        state_d  = ST_LEN1;
      end
      ST_LEN1: if (xfer) begin
        n_d[15:8] = s_data;
        state_d   = {1'b0, s_data, n_q[7:0]} > CAP ? ST_ERROR :
                    {s_data, n_q[7:0]} == 16'd0 ? ST_CHECK : ST_DATA;
      end
      // idx_q already counts every earlier word: writes land 1 cycle after a lane-3 byte, words take >= 4 cycles
      ST_DATA: if (xfer) begin
        chk_d = chk_q ^ s_data;
        if (lane == 2'd3 && idx_q == n_q - 16'd1) state_d = ST_CHECK;
      end
      ST_CHECK: if (xfer) state_d = s_data == chk_q ? ST_DONE : ST_ERROR;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
    end
  end
  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear),
    .byte_en_i  (xfer && state_q == ST_DATA),
    .data_i     (s_data),
    .lane_o     (lane),
    .word_vld_o (imem_we),
    .word_o     (imem_wd)
  );
  assign imem_addr  = idx_q[ADDR_WIDTH-1:0];
  assign core_reset = state_q != ST_DONE;
  assign done       = state_q == ST_DONE;
  assign error      = state_q == ST_ERROR;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frames checked against a frame-level reference model.
module tb_imem_loader;
  localparam int AW = 4;
  localparam int CAPW = 1 << AW;
  typedef logic [7:0] bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic s_ready, imem_we, core_reset, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wd;
  int tests = 0, fails = 0;
  logic [31:0] got_a[$], got_d[$];
  logic prev_we = 1'b0, b2b = 1'b0;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      got_a.push_back(32'(imem_addr));
      got_d.push_back(imem_wd);
      if (prev_we) b2b = 1'b1;
    end
    prev_we = imem_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bq_t build(input wq_t w);
    bq_t f;
    logic [7:0] x = '0;
    logic [15:0] n = 16'(w.size());
    f.push_back(n[7:0]);
    f.push_back(n[15:8]);
    foreach (w[k]) for (int b = 0; b < 4; b++) begin
      f.push_back(w[k][8*b +: 8]);
      x ^= w[k][8*b +: 8];
    end
    f.push_back(x);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
    int cnt = 0;
    while (gap > 0 && $urandom_range(99) < gap) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    start   = st;
    while (!s_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("s_ready", {31'b0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_frame(input bq_t fr, input int gap, input int start_at, input string tag);
    int n, nbytes, cnt;
    logic ok;
    logic [7:0] x = '0;
    wq_t exp_w;
    n = {fr[1], fr[0]};
    if (n > CAPW) begin
      nbytes = 2;
      ok = 1'b0;
    end else begin
      nbytes = 3 + 4 * n;
      for (int k = 0; k < n; k++) exp_w.push_back({fr[2+4*k+3], fr[2+4*k+2], fr[2+4*k+1], fr[2+4*k]});
      for (int i = 2; i < 2 + 4 * n; i++) x ^= fr[i];
      ok = fr[2+4*n] == x;
    end
    got_a.delete();
    got_d.delete();
    b2b = 1'b0;
    pulse_start();
    chk({tag, " load_done"}, {31'b0, done}, 32'd0);
    chk({tag, " load_err"}, {31'b0, error}, 32'd0);
    chk({tag, " load_corerst"}, {31'b0, core_reset}, 32'd1);
    for (int i = 0; i < nbytes; i++) send_byte(fr[i], gap, i == start_at);
    cnt = 0;
    while (!(done || error) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " settle"}, 32'(cnt), 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, " nwrites"}, 32'(got_a.size()), 32'(exp_w.size()));
    foreach (exp_w[k]) if (k < got_a.size()) begin
      chk($sformatf("%s addr%0d", tag, k), got_a[k], 32'(k));
      chk($sformatf("%s word%0d", tag, k), got_d[k], exp_w[k]);
    end
    chk({tag, " b2b_we"}, {31'b0, b2b}, 32'd0);
    chk({tag, " done"}, {31'b0, done}, {31'b0, ok});
    chk({tag, " error"}, {31'b0, error}, {31'b0, !ok});
    chk({tag, " core_reset"}, {31'b0, core_reset}, {31'b0, !ok});
  endtask

  initial begin
    bq_t f1, f;
    wq_t w;
    w = '{32'h00500093, 32'h00A00113};
    f1 = build(w);
    repeat (3) @(posedge clk);
    #1;
    chk("rst s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst imem_we", {31'b0, imem_we}, 32'd0);
    chk("rst imem_addr", 32'(imem_addr), 32'd0);
    chk("rst imem_wd", imem_wd, 32'd0);
    chk("rst core_reset", {31'b0, core_reset}, 32'd1);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst error", {31'b0, error}, 32'd0);
    @(negedge clk) reset = 1'b0;

    run_frame(f1, 0, -1, "f1");
    f = f1;
    f[f.size()-1] = 8'h00;
    run_frame(f, 0, -1, "f1_badchk");
    run_frame('{8'h00, 8'h00, 8'h00}, 0, -1, "len0_ok");
    run_frame('{8'h00, 8'h00, 8'h01}, 0, -1, "len0_bad");
    run_frame('{8'h11, 8'h00}, 0, -1, "len17");
    w.delete();
    for (int k = 0; k < CAPW; k++) w.push_back($urandom);
    run_frame(build(w), 0, -1, "len16");
    run_frame(f1, 50, -1, "f1_gaps");
    run_frame(f1, 0, 5, "f1_midstart");

    got_a.delete();
    got_d.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(f1[i], 0, 1'b0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort s_ready", {31'b0, s_ready}, 32'd0);
    chk("abort core_reset", {31'b0, core_reset}, 32'd1);
    chk("abort imem_we", {31'b0, imem_we}, 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort nwrites", 32'(got_a.size()), 32'd1);
    if (got_a.size() > 0) chk("abort word0", got_d[0], 32'h00500093);
    chk("abort done", {31'b0, done}, 32'd0);
    run_frame(f1, 0, -1, "f1_after_abort");

    for (int r = 0; r < 4; r++) begin
      w.delete();
      for (int k = 0; k < $urandom_range(1, CAPW); k++) w.push_back($urandom);
      f = build(w);
      if ($urandom_range(1) == 1) f[f.size()-1] ^= 8'(1 << $urandom_range(7));
      run_frame(f, 50, -1, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
